// File: rtl/instr_fetch_ctrl_pkg.sv
// Shared types and constants for the instruction fetch controller.
// Holds the FSM state encoding, the word size in bytes and the prefetch
// entry layout (byte address + instruction word) stored in the fetch FIFO.
package instr_fetch_pkg;

   localparam int FETCH_ADDR_W = 16;
   localparam int FETCH_DATA_W = 32;
   localparam int WORD_BYTES   = FETCH_DATA_W / 8;

   typedef enum logic {
      IDLE  = 1'b0,
      FETCH = 1'b1
   } fsm_t;

   typedef struct packed {
      logic [FETCH_ADDR_W-1:0] addr;
      logic [FETCH_DATA_W-1:0] rdata;
   } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_ctrl_if.sv
// Bundles the instruction memory read port and the core-facing instruction stream.
// master: fetch controller side (drives mem_en_o/mem_addr_o and the instr_* stream).
// slave : memory + core side (drives mem_rdata_i and instr_ready_i).
interface instr_fetch_ctrl_if #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 32
);
   logic                  mem_en_o;
   logic [ADDR_WIDTH-1:0] mem_addr_o;
   logic [DATA_WIDTH-1:0] mem_rdata_i;

   logic                  instr_valid_o;
   logic                  instr_ready_i;
   logic [DATA_WIDTH-1:0] instr_rdata_o;
   logic [ADDR_WIDTH-1:0] instr_addr_o;

   modport master (
      output mem_en_o, mem_addr_o, instr_valid_o, instr_rdata_o, instr_addr_o,
      input  mem_rdata_i, instr_ready_i
   );

   modport slave (
      input  mem_en_o, mem_addr_o, instr_valid_o, instr_rdata_o, instr_addr_o,
      output mem_rdata_i, instr_ready_i
   );
endinterface

// File: rtl/instr_fetch_ctrl_fifo.sv
// Purpose : synchronous prefetch FIFO of fetch entries with flush; head is read from storage.
// Latency : a push is visible at the head the cycle after the push edge.
// Backpr. : pushes while full and pops while empty are ignored; flush has priority over both.
// Ports   : clk, rst_n, push/push_data, pop, flush in; head, count out.
module fetch_fifo
   import instr_fetch_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int PW    = $clog2(DEPTH),
   localparam int CW    = PW + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  fetch_entry_t  push_data,
   input  logic          pop,
   input  logic          flush,
   output fetch_entry_t  head,
   output logic [CW-1:0] count
);

   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   fetch_entry_t  mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign do_push = push && (count != FULL_CNT);
   assign do_pop  = pop  && (count != '0);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + PW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Purpose : sequential instruction prefetcher for a 1-cycle-latency en/addr/rdata memory,
//           delivering words to the core over valid/ready, with branch redirect + flush.
// Latency : fetch_en sampled at edge 0 -> first read in cycle 1 -> instr_valid_o in cycle 3.
// Backpr. : reads issue only while FIFO count + in-flight read < FIFO_DEPTH, so a
//           returning word always has a slot; a pop in the same cycle is not credited.
// Ports   : clk, rst_n, fetch_en_i, branch_i, branch_addr_i, plus bus (master modport)
//           carrying mem_en_o/mem_addr_o/mem_rdata_i and instr_valid/ready/rdata/addr.
//           ADDR_WIDTH/DATA_WIDTH must match the package entry layout.
module instr_fetch_ctrl
   import instr_fetch_pkg::*;
#(
   parameter int                    ADDR_WIDTH = 16,
   parameter int                    DATA_WIDTH = 32,
   parameter int                    FIFO_DEPTH = 4,
   parameter logic [ADDR_WIDTH-1:0] BOOT_ADDR  = 16'h0000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  fetch_en_i,
   input  logic                  branch_i,
   input  logic [ADDR_WIDTH-1:0] branch_addr_i,
   instr_fetch_ctrl_if.master    bus
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [ADDR_WIDTH-1:0] ADDR_STEP  = ADDR_WIDTH'(WORD_BYTES);
   localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(WORD_BYTES - 1);
   localparam logic [CW:0]           DEPTH_LIM  = (CW + 1)'(FIFO_DEPTH);

   fsm_t                  state;
   logic [ADDR_WIDTH-1:0] fetch_addr;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic                  inflight;
   logic                  drop;
   logic [CW-1:0]         count;
   logic [CW:0]           occupancy;
   logic                  issue;
   logic                  push;
   logic                  pop;
   logic                  instr_valid;
   fetch_entry_t          push_entry;
   fetch_entry_t          head;

   // The outstanding read counts as occupied so its response can never overflow.
   assign occupancy = {1'b0, count} + {{CW{1'b0}}, inflight};
   assign issue     = (state == FETCH) && !branch_i && (occupancy < DEPTH_LIM);

   // A response arriving after a redirect belongs to the old stream and is discarded.
   assign push        = inflight && !drop;
   assign instr_valid = (count != '0);
   assign pop         = instr_valid && bus.instr_ready_i;

   always_comb begin
      push_entry       = '0;
      push_entry.addr  = req_addr;
      push_entry.rdata = bus.mem_rdata_i;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         fetch_addr <= BOOT_ADDR;
         req_addr   <= '0;
         inflight   <= 1'b0;
         drop       <= 1'b0;
      end else begin
         case (state)
            IDLE:    if (fetch_en_i)  state <= FETCH;
            FETCH:   if (!fetch_en_i) state <= IDLE;
            default: state <= IDLE;
         endcase

         if (branch_i) begin
            fetch_addr <= branch_addr_i & ALIGN_MASK;
            inflight   <= 1'b0;
            drop       <= inflight;
         end else begin
            drop <= 1'b0;
            if (issue) begin
               fetch_addr <= fetch_addr + ADDR_STEP;
               req_addr   <= fetch_addr;
               inflight   <= 1'b1;
            end else begin
               inflight   <= 1'b0;
            end
         end
      end
   end

   // Branch flushes the queue; flush outranks a same-cycle push or pop.
   fetch_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_data (push_entry),
      .pop       (pop),
      .flush     (branch_i),
      .head      (head),
      .count     (count)
   );

   assign bus.mem_en_o      = issue;
   assign bus.mem_addr_o    = fetch_addr;
   assign bus.instr_valid_o = instr_valid;
   assign bus.instr_rdata_o = head.rdata;
   assign bus.instr_addr_o  = head.addr;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed bench for instr_fetch_ctrl: boot fetch, backpressure, branch with a
// read in flight, branch + ready, address wrap and reset mid-stream.
// The memory model returns {16'h0, addr} one cycle after each read strobe.
module tb_instr_fetch_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        fetch_en_i;
   logic        branch_i;
   logic [15:0] branch_addr_i;

   int vectors     = 0;
   int miscompares = 0;
   int issues      = 0;
   int base;

   instr_fetch_ctrl_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) bus ();

   instr_fetch_ctrl #(
      .ADDR_WIDTH (16),
      .DATA_WIDTH (32),
      .FIFO_DEPTH (4),
      .BOOT_ADDR  (16'h0000)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .fetch_en_i    (fetch_en_i),
      .branch_i      (branch_i),
      .branch_addr_i (branch_addr_i),
      .bus           (bus)
   );

   always #5 clk = ~clk;

   // One-cycle-latency memory: data word equals its byte address.
   always @(posedge clk) begin
      if (bus.mem_en_o) bus.mem_rdata_i <= {16'h0000, bus.mem_addr_o};
   end

   always @(posedge clk) begin
      if (bus.mem_en_o) issues <= issues + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, ".valid"}, 32'(bus.instr_valid_o), 32'd0);
      chk({tag, ".rdata"}, bus.instr_rdata_o, 32'd0);
      chk({tag, ".iaddr"}, 32'(bus.instr_addr_o), 32'd0);
      chk({tag, ".mem_en"}, 32'(bus.mem_en_o), 32'd0);
      chk({tag, ".mem_addr"}, 32'(bus.mem_addr_o), 32'd0);
   endtask

   task automatic chk_mem(input string tag, input logic en, input logic [15:0] addr);
      chk({tag, ".mem_en"}, 32'(bus.mem_en_o), 32'(en));
      if (en) chk({tag, ".mem_addr"}, 32'(bus.mem_addr_o), 32'(addr));
   endtask

   task automatic chk_head(input string tag, input logic vld, input logic [15:0] addr);
      chk({tag, ".valid"}, 32'(bus.instr_valid_o), 32'(vld));
      if (vld) begin
         chk({tag, ".iaddr"}, 32'(bus.instr_addr_o), 32'(addr));
         chk({tag, ".rdata"}, bus.instr_rdata_o, {16'h0000, addr});
      end
   endtask

   initial begin
      rst_n             = 1'b0;
      fetch_en_i        = 1'b0;
      branch_i          = 1'b0;
      branch_addr_i     = 16'h0000;
      bus.instr_ready_i = 1'b1;
      #3;
      chk_reset_vals("rst");

      // ---- boot fetch ----
      tick();
      rst_n = 1'b1; fetch_en_i = 1'b1; #1;
      chk_mem("boot.idle", 1'b0, 16'h0000);
      tick(); #1; chk_mem("boot.c1", 1'b1, 16'h0000); chk_head("boot.c1", 1'b0, 16'h0);
      tick(); #1; chk_mem("boot.c2", 1'b1, 16'h0004); chk_head("boot.c2", 1'b0, 16'h0);
      tick(); #1; chk_mem("boot.c3", 1'b1, 16'h0008); chk_head("boot.c3", 1'b1, 16'h0000);
      tick(); #1; chk_mem("boot.c4", 1'b1, 16'h000C); chk_head("boot.c4", 1'b1, 16'h0004);
      tick(); #1; chk_mem("boot.c5", 1'b1, 16'h0010); chk_head("boot.c5", 1'b1, 16'h0008);

      // ---- reset mid-stream with 2 queued and a read in flight ----
      bus.instr_ready_i = 1'b0;
      tick(); #1; chk_mem("mid.c6", 1'b1, 16'h0014); chk_head("mid.c6", 1'b1, 16'h0008);
      rst_n = 1'b0; #1;
      chk_reset_vals("mid.rst");
      tick();
      rst_n = 1'b1; bus.instr_ready_i = 1'b1; #1;
      chk_mem("mid.idle", 1'b0, 16'h0000); chk_head("mid.idle", 1'b0, 16'h0);
      tick(); #1; chk_mem("mid.c1", 1'b1, 16'h0000); chk_head("mid.c1", 1'b0, 16'h0);
      tick(); #1; chk_mem("mid.c2", 1'b1, 16'h0004); chk_head("mid.c2", 1'b0, 16'h0);
      tick(); #1; chk_head("mid.c3", 1'b1, 16'h0000);

      // ---- backpressure from a fresh boot ----
      rst_n = 1'b0; bus.instr_ready_i = 1'b0;
      tick();
      rst_n = 1'b1; base = issues;
      repeat (7) tick();
      #1;
      chk("bp.issues", 32'(issues - base), 32'd4);
      chk_mem("bp.full", 1'b0, 16'h0000);
      chk_head("bp.full", 1'b1, 16'h0000);
      bus.instr_ready_i = 1'b1; #1;
      chk_mem("bp.pop_not_credited", 1'b0, 16'h0000);
      tick(); #1; chk_mem("bp.r1", 1'b1, 16'h0010); chk_head("bp.r1", 1'b1, 16'h0004);
      tick(); #1; chk_mem("bp.r2", 1'b1, 16'h0014); chk_head("bp.r2", 1'b1, 16'h0008);
      tick(); #1; chk_head("bp.r3", 1'b1, 16'h000C);
      tick(); #1; chk_head("bp.r4", 1'b1, 16'h0010);
      tick(); #1; chk_head("bp.r5", 1'b1, 16'h0014);

      // ---- branch with read of 0x0008 in flight ----
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick(); #1; chk_mem("br.c1", 1'b1, 16'h0000);
      tick(); #1; chk_mem("br.c2", 1'b1, 16'h0004);
      tick(); #1; chk_mem("br.c3", 1'b1, 16'h0008);
      tick();
      branch_i = 1'b1; branch_addr_i = 16'h0200; #1;
      chk_mem("br.c4", 1'b0, 16'h0000);
      tick();
      branch_i = 1'b0; #1;
      chk_mem("br.c5", 1'b1, 16'h0200); chk_head("br.c5", 1'b0, 16'h0);
      tick(); #1; chk_mem("br.c6", 1'b1, 16'h0204); chk_head("br.c6", 1'b0, 16'h0);
      tick(); #1; chk_head("br.c7", 1'b1, 16'h0200);
      tick(); #1; chk_head("br.c8", 1'b1, 16'h0204);

      // ---- branch + ready with 3 entries queued; target low bits masked ----
      bus.instr_ready_i = 1'b0;
      tick(); #1; chk_mem("bq.c9", 1'b1, 16'h0210); chk_head("bq.c9", 1'b1, 16'h0204);
      tick(); #1; chk_mem("bq.c10", 1'b0, 16'h0000); chk_head("bq.c10", 1'b1, 16'h0204);
      branch_i = 1'b1; branch_addr_i = 16'h0301; bus.instr_ready_i = 1'b1;
      tick();
      branch_i = 1'b0; #1;
      chk_mem("bq.c11", 1'b1, 16'h0300); chk_head("bq.c11", 1'b0, 16'h0);
      tick(); #1; chk_mem("bq.c12", 1'b1, 16'h0304); chk_head("bq.c12", 1'b0, 16'h0);
      tick(); #1; chk_head("bq.c13", 1'b1, 16'h0300);
      tick(); #1; chk_head("bq.c14", 1'b1, 16'h0304);

      // ---- wrap-around ----
      branch_i = 1'b1; branch_addr_i = 16'hFFFC; #1;
      chk_mem("wr.br", 1'b0, 16'h0000);
      tick();
      branch_i = 1'b0; #1;
      chk_mem("wr.c15", 1'b1, 16'hFFFC); chk_head("wr.c15", 1'b0, 16'h0);
      tick(); #1; chk_mem("wr.c16", 1'b1, 16'h0000);
      tick(); #1; chk_mem("wr.c17", 1'b1, 16'h0004); chk_head("wr.c17", 1'b1, 16'hFFFC);
      tick(); #1; chk_head("wr.c18", 1'b1, 16'h0000);
      tick(); #1; chk_head("wr.c19", 1'b1, 16'h0004);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
